// File: rtl/vram_wb_dp.sv
// vram_wb_dp: dual-port video RAM with Wishbone-style CPU port and read-only VGA port
module vram_wb_dp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 1200,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [31:0]       adr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              we_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              err_o,
  input  logic              vga_en,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_dout
);
  typedef enum logic {IDLE, RESP} state_t;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  logic [DATA_W-1:0] mem [DEPTH];
  state_t state_q, state_d;
  logic ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0] dat_q, dat_d, vga_q, vga_d;
  logic [ADDR_W-1:0] idx;
  logic acc, in_rng, vga_rng, wr;
  logic unused_bits;
  assign unused_bits = ^{adr_i[31:ADDR_W+2], adr_i[1:0]};
  assign idx = adr_i[ADDR_W+1:2];
  always_comb begin
    in_rng  = {1'b0, idx} < DEPTH_L;
    vga_rng = {1'b0, vga_addr} < DEPTH_L;
    acc     = state_q == IDLE && cyc_i && stb_i;
    wr      = acc && we_i && in_rng && !rst;
    state_d = acc ? RESP : IDLE;
    ack_d   = acc && in_rng;
    err_d   = acc && !in_rng;
    dat_d   = (acc && !we_i) ? (in_rng ? mem[idx] : '0) : dat_q;
    vga_d   = vga_en ? (vga_rng ? mem[vga_addr] : '0) : vga_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      vga_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      vga_q   <= vga_d;
    end
  end
  // Non-blocking write alongside the VGA read gives read-first collision behaviour
  always_ff @(posedge clk) begin
    if (wr)
      for (int k = 0; k < SEL_W; k++)
        if (sel_i[k]) mem[idx][8*k +: 8] <= dat_i[8*k +: 8];
  end
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign dat_o    = dat_q;
  assign vga_dout = vga_q;
endmodule

// File: tb/tb_vram_wb_dp.sv
// tb_vram_wb_dp: directed self-checking bench for vram_wb_dp
module tb_vram_wb_dp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dat_i = '0, adr_i = '0;
  logic [3:0]  sel_i = '0;
  logic        we_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0;
  logic [31:0] dat_o, vga_dout;
  logic        ack_o, err_o, vga_en = 1'b0;
  logic [10:0] vga_addr = '0;
  int n_chk = 0, n_err = 0;
  vram_wb_dp dut (
    .clk(clk), .rst(rst), .dat_i(dat_i), .adr_i(adr_i), .sel_i(sel_i), .we_i(we_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .vga_en(vga_en), .vga_addr(vga_addr), .vga_dout(vga_dout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = d; sel_i = sel;
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask
  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel, input logic bad);
    req(1'b1, adr, d, sel);
    chk({tag, "_ack"}, 32'(ack_o), 32'(!bad));
    chk({tag, "_err"}, 32'(err_o), 32'(bad));
  endtask
  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp, input logic bad);
    req(1'b0, adr, 32'h0, 4'h0);
    chk({tag, "_ack"}, 32'(ack_o), 32'(!bad));
    chk({tag, "_err"}, 32'(err_o), 32'(bad));
    chk({tag, "_dat"}, dat_o, exp);
  endtask
  initial begin
    int acks;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_vga", vga_dout, 0);
    rst = 1'b0;
    wr("w10", 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack_o), 0);
    rd("r10", 32'h10, 32'hDEADBEEF, 1'b0);
    wr("wlane", 32'h10, 32'h00000055, 4'b0001, 1'b0);
    rd("rlane", 32'h10, 32'hDEADBE55, 1'b0);
    wr("wsel0", 32'h10, 32'h0, 4'h0, 1'b0);
    rd("rsel0", 32'h10, 32'hDEADBE55, 1'b0);
    rd("rhi_ign", 32'h8000_2013, 32'hDEADBE55, 1'b0);
    wr("w0", 32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
    wr("w1199", 32'h12BC, 32'h11112222, 4'hF, 1'b0);
    wr("woor", 32'h12C0, 32'hFFFFFFFF, 4'hF, 1'b1);
    rd("roor", 32'h12C0, 32'h0, 1'b1);
    rd("r0", 32'h0, 32'hCAFEF00D, 1'b0);
    rd("r1199", 32'h12BC, 32'h11112222, 1'b0);
    wr("w7", 32'h1C, 32'h0000AAAA, 4'hF, 1'b0);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h1C; dat_i = 32'h1234; sel_i = 4'hF;
    vga_en = 1'b1; vga_addr = 11'd7;
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    chk("vga_old", vga_dout, 32'h0000AAAA);
    @(negedge clk);
    chk("vga_new", vga_dout, 32'h1234);
    vga_en = 1'b0; vga_addr = 11'd0;
    repeat (2) @(negedge clk);
    chk("vga_hold", vga_dout, 32'h1234);
    vga_en = 1'b1; vga_addr = 11'd1200;
    @(negedge clk);
    chk("vga_oor", vga_dout, 0);
    vga_addr = 11'd4;
    @(negedge clk);
    chk("vga_w4", vga_dout, 32'hDEADBE55);
    vga_en = 1'b0;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h10;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack%0d", i), 32'(ack_o), 32'(i % 2 == 0));
      acks += int'(ack_o);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    chk("b2b_count", 32'(acks), 3);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h40; dat_i = 32'hA5A5A5A5; sel_i = 4'hF;
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    chk("resp_ack", 32'(ack_o), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ack", 32'(ack_o), 0);
    chk("mrst_err", 32'(err_o), 0);
    chk("mrst_dat", dat_o, 0);
    chk("mrst_vga", vga_dout, 0);
    rst = 1'b0;
    rd("r_kept", 32'h40, 32'hA5A5A5A5, 1'b0);
    wr("w44", 32'h44, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    rst = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h44; dat_i = 32'h77; sel_i = 4'hF;
    @(negedge clk);
    rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    chk("rstreq_ack", 32'(ack_o), 0);
    @(negedge clk);
    chk("rstreq_idle", 32'(ack_o), 0);
    rd("rstreq_nowr", 32'h44, 32'h0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
